// File: rtl/sha256_msg_sched_if.sv
// Bus between the compression-core FSM and the SHA-256 message scheduler.
//   load_block_i  : load block_i into the schedule window on this edge
//   update_w_i    : advance the schedule by one word on this edge
//   block_i       : 512-bit block, big-endian words (M0 = block_i[511:480])
//   w_t_current_o : current schedule word W[t]
// master = core FSM side, slave = scheduler side.
interface sha256_msg_sched_if;
  logic         load_block_i;
  logic         update_w_i;
  logic [511:0] block_i;
  logic [31:0]  w_t_current_o;

  modport master (
    output load_block_i,
    output update_w_i,
    output block_i,
    input  w_t_current_o
  );

  modport slave (
    input  load_block_i,
    input  update_w_i,
    input  block_i,
    output w_t_current_o
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256/SHA-224 message schedule (W-expansion) engine.
// Keeps a sliding 16-word window; slot 0 is the current round word W[t]. Each update
// shifts the window down one slot and appends the next expanded word at slot 15.
// Ports:
//   clk   : system clock, rising-edge
//   rst_n : asynchronous active-low reset, clears the window
//   bus   : sha256_msg_sched_if.slave (load/update strobes, block in, W[t] out)
module sha256_msg_sched (
  input logic                clk,
  input logic                rst_n,
  sha256_msg_sched_if.slave  bus
);

  logic [15:0][31:0] win_q, win_d;
  logic [31:0]       w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], window slot k holds W[t+k]
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    win_d = win_q;
    if (bus.load_block_i) begin
      // Load takes priority over a coincident update
      for (int i = 0; i < 16; i++) begin
        win_d[i] = bus.block_i[511 - 32 * i -: 32];
      end
    end else if (bus.update_w_i) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[15] = w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign bus.w_t_current_o = win_q[0];

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic clk;
  logic rst_n;
  sha256_msg_sched_if bus_if ();

  sha256_msg_sched u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic        upd;
    logic [31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] blk_abc;
  logic [511:0] blk_two;
  logic [31:0]  ref_w [0:79];
  vec_t         vecs [0:19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive strobes, take one rising edge, leave inputs idle, sample 1 time unit later.
  task automatic step(input logic load, input logic upd);
    bus_if.load_block_i = load;
    bus_if.update_w_i   = upd;
    @(posedge clk);
    #1;
    bus_if.load_block_i = 1'b0;
    bus_if.update_w_i   = 1'b0;
  endtask

  // Straight FIPS 180-4 schedule over an 80-entry array.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref(input logic [511:0] b);
    for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32 * t -: 32];
    for (int t = 16; t < 80; t++) begin
      ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
               + ref_w[t-7]
               + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
               + ref_w[t-16];
    end
  endtask

  initial begin
    blk_abc = '0;
    blk_abc[511:480] = 32'h6162_6380;
    blk_abc[31:0]    = 32'h0000_0018;
    blk_two = '0;
    blk_two[511:480] = 32'hDEAD_BEEF;
    blk_two[479:448] = 32'h0123_4567;

    // Hand-computed "abc" schedule W0..W19
    vecs[0] = '{1'b1, 1'b0, 32'h6162_6380};
    for (int k = 1; k < 15; k++) vecs[k] = '{1'b0, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0018};
    vecs[16] = '{1'b0, 1'b1, 32'h6162_6380};
    vecs[17] = '{1'b0, 1'b1, 32'h000F_0000};
    vecs[18] = '{1'b0, 1'b1, 32'h7DA8_6405};
    vecs[19] = '{1'b0, 1'b1, 32'h6000_03C6};

    bus_if.load_block_i = 1'b0;
    bus_if.update_w_i   = 1'b0;
    bus_if.block_i      = blk_abc;
    rst_n = 1'b0;
    #12;
    check("reset_initial", bus_if.w_t_current_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Table: load then 19 updates at full throughput
    for (int k = 0; k < 20; k++) begin
      step(vecs[k].load, vecs[k].upd);
      check($sformatf("abc_w%0d", k), bus_if.w_t_current_o, vecs[k].exp);
    end

    // Asynchronous reset mid-clock: clears without an edge, holds while low
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", bus_if.w_t_current_o, 32'h0);
    step(1'b1, 1'b1);
    check("reset_hold_1", bus_if.w_t_current_o, 32'h0);
    step(1'b0, 1'b1);
    check("reset_hold_2", bus_if.w_t_current_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Hold: 5 updates, 10 idle cycles at W5, then resume to W19
    step(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      check($sformatf("hold_w5_c%0d", k), bus_if.w_t_current_o, 32'h0);
    end
    for (int k = 6; k < 20; k++) begin
      step(1'b0, 1'b1);
      check($sformatf("resume_w%0d", k), bus_if.w_t_current_o, vecs[k].exp);
    end

    // Priority: load and update together with a new block
    bus_if.block_i = blk_two;
    step(1'b1, 1'b1);
    check("prio_load_wins", bus_if.w_t_current_o, 32'hDEAD_BEEF);
    step(1'b0, 1'b1);
    check("prio_next_m1", bus_if.w_t_current_o, 32'h0123_4567);

    // Full run of 64 updates against the reference schedule, then reload
    bus_if.block_i = blk_abc;
    build_ref(blk_abc);
    step(1'b1, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      step(1'b0, 1'b1);
      check($sformatf("run_w%0d", k), bus_if.w_t_current_o, ref_w[k]);
    end
    step(1'b1, 1'b0);
    check("reload_m0", bus_if.w_t_current_o, 32'h6162_6380);

    // Reset pulse during round 30, then a clean restart
    for (int k = 1; k <= 30; k++) step(1'b0, 1'b1);
    check("pre_reset_w30", bus_if.w_t_current_o, ref_w[30]);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_run_reset", bus_if.w_t_current_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 19; k++) begin
      step(vecs[k].load, vecs[k].upd);
      check($sformatf("restart_w%0d", k), bus_if.w_t_current_o, vecs[k].exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
